// File: rtl/axis_stats_pkg.sv
// Shared definitions for the AXI-Stream statistics blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_stats_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stat_state_t;

    // Ethernet runt / giant thresholds, shared by all stats collectors.
    localparam int DEFAULT_MIN_LEN = 64;
    localparam int DEFAULT_MAX_LEN = 1518;

endpackage

// File: rtl/axis_sat_counter.sv
// Saturating accumulator; count_upd is the value taken this edge when clear is low.
// Latency: 1 cycle from inc_en to the stored value; count_upd is combinational.
// Backpressure: none; clear wins over a same-cycle increment.
module axis_sat_counter #(
    parameter int WIDTH     = 32,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc_en,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     count_upd
);

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum       = {1'b0, count} + (WIDTH+1)'(inc);
        count_upd = count;
        if (inc_en) begin
            count_upd = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count_upd;
        end
    end

endmodule

// File: rtl/axis_frame_len_stats.sv
// Per-period frame length statistics with a valid/ready snapshot port.
// Latency: 1 cycle from frame_len_valid to live stats, 1 cycle from snapshot_req to stat_valid.
// Backpressure: no input backpressure; requests arriving while a snapshot is held are dropped and flagged.
module axis_frame_len_stats
    import axis_stats_pkg::*;
#(
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 32,
    parameter int BYTE_WIDTH  = 48,
    parameter int MIN_LEN     = DEFAULT_MIN_LEN,
    parameter int MAX_LEN     = DEFAULT_MAX_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN_WIDTH-1:0]   frame_len,
    input  logic                   frame_len_valid,
    input  logic                   snapshot_req,
    input  logic                   snapshot_clear,
    output logic                   stat_valid,
    input  logic                   stat_ready,
    output logic [COUNT_WIDTH-1:0] stat_frames,
    output logic [BYTE_WIDTH-1:0]  stat_bytes,
    output logic [LEN_WIDTH-1:0]   stat_min_len,
    output logic [LEN_WIDTH-1:0]   stat_max_len,
    output logic [COUNT_WIDTH-1:0] stat_runts,
    output logic [COUNT_WIDTH-1:0] stat_giants,
    output logic                   snapshot_overrun
);

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

    stat_state_t            state;
    logic                   live_clear;
    logic                   is_runt;
    logic                   is_giant;
    logic [COUNT_WIDTH-1:0] frames_upd;
    logic [COUNT_WIDTH-1:0] runts_upd;
    logic [COUNT_WIDTH-1:0] giants_upd;
    logic [BYTE_WIDTH-1:0]  bytes_upd;
    logic [LEN_WIDTH-1:0]   min_len;
    logic [LEN_WIDTH-1:0]   max_len;
    logic [LEN_WIDTH-1:0]   min_upd;
    logic [LEN_WIDTH-1:0]   max_upd;

    // Only an accepted request may clear; a dropped one leaves the period running.
    assign live_clear = (state == ST_IDLE) && snapshot_req && snapshot_clear;
    assign is_runt    = frame_len_valid && (frame_len < MIN_L);
    assign is_giant   = frame_len_valid && (frame_len > MAX_L);

    axis_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_frames (
        .clk(clk), .rst(rst), .clear(live_clear), .inc_en(frame_len_valid),
        .inc(1'b1), .count_upd(frames_upd)
    );

    axis_sat_counter #(.WIDTH(BYTE_WIDTH), .INC_WIDTH(LEN_WIDTH)) u_bytes (
        .clk(clk), .rst(rst), .clear(live_clear), .inc_en(frame_len_valid),
        .inc(frame_len), .count_upd(bytes_upd)
    );

    axis_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_runts (
        .clk(clk), .rst(rst), .clear(live_clear), .inc_en(is_runt),
        .inc(1'b1), .count_upd(runts_upd)
    );

    axis_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_giants (
        .clk(clk), .rst(rst), .clear(live_clear), .inc_en(is_giant),
        .inc(1'b1), .count_upd(giants_upd)
    );

    always_comb begin
        min_upd = min_len;
        max_upd = max_len;
        if (frame_len_valid && (frame_len < min_len)) begin
            min_upd = frame_len;
        end
        if (frame_len_valid && (frame_len > max_len)) begin
            max_upd = frame_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_len <= '1;
            max_len <= '0;
        end else if (live_clear) begin
            min_len <= '1;
            max_len <= '0;
        end else begin
            min_len <= min_upd;
            max_len <= max_upd;
        end
    end

    // Shadows capture the *_upd values so a frame landing with the request is in the snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            stat_valid       <= 1'b0;
            stat_frames      <= '0;
            stat_bytes       <= '0;
            stat_min_len     <= '1;
            stat_max_len     <= '0;
            stat_runts       <= '0;
            stat_giants      <= '0;
            snapshot_overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (snapshot_req) begin
                        state        <= ST_HOLD;
                        stat_valid   <= 1'b1;
                        stat_frames  <= frames_upd;
                        stat_bytes   <= bytes_upd;
                        stat_min_len <= min_upd;
                        stat_max_len <= max_upd;
                        stat_runts   <= runts_upd;
                        stat_giants  <= giants_upd;
                    end
                end
                ST_HOLD: begin
                    if (snapshot_req) begin
                        snapshot_overrun <= 1'b1;
                    end
                    if (stat_ready) begin
                        state      <= ST_IDLE;
                        stat_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Directed bench: two DUTs (default widths and 4-bit counters) share one stimulus stream,
// checked every cycle against a queue-based model plus hand-computed snapshot values.
module tb_axis_frame_len_stats;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] flen = '0;
    logic        flv = 1'b0;
    logic        req = 1'b0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;

    logic        a_valid, a_ovr;
    logic [31:0] a_frames, a_runts, a_giants;
    logic [47:0] a_bytes;
    logic [15:0] a_min, a_max;

    logic        b_valid, b_ovr;
    logic [3:0]  b_frames, b_runts, b_giants;
    logic [47:0] b_bytes;
    logic [15:0] b_min, b_max;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axis_frame_len_stats dut (
        .clk(clk), .rst(rst), .frame_len(flen), .frame_len_valid(flv),
        .snapshot_req(req), .snapshot_clear(clr), .stat_valid(a_valid), .stat_ready(rdy),
        .stat_frames(a_frames), .stat_bytes(a_bytes), .stat_min_len(a_min),
        .stat_max_len(a_max), .stat_runts(a_runts), .stat_giants(a_giants),
        .snapshot_overrun(a_ovr)
    );

    axis_frame_len_stats #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .frame_len(flen), .frame_len_valid(flv),
        .snapshot_req(req), .snapshot_clear(clr), .stat_valid(b_valid), .stat_ready(rdy),
        .stat_frames(b_frames), .stat_bytes(b_bytes), .stat_min_len(b_min),
        .stat_max_len(b_max), .stat_runts(b_runts), .stat_giants(b_giants),
        .snapshot_overrun(b_ovr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- model: frames of the live period kept as a list ----------------
    longint q[$];
    bit     m_valid, m_ovr;
    longint e_fr, e_by, e_mn, e_mx, e_ru, e_gi;
    longint e4_fr, e4_ru, e4_gi;

    function automatic void stats(input longint cmax, output longint fr, output longint by,
                                  output longint mn, output longint mx, output longint ru,
                                  output longint gi);
        fr = 0; by = 0; mn = 64'hFFFF; mx = 0; ru = 0; gi = 0;
        foreach (q[i]) begin
            fr++;
            by += q[i];
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
            if (q[i] < 64) ru++;
            if (q[i] > 1518) gi++;
        end
        if (fr > cmax) fr = cmax;
        if (ru > cmax) ru = cmax;
        if (gi > cmax) gi = cmax;
    endfunction

    task automatic m_reset();
        q.delete();
        m_valid = 0; m_ovr = 0;
        e_fr = 0; e_by = 0; e_mn = 64'hFFFF; e_mx = 0; e_ru = 0; e_gi = 0;
        e4_fr = 0; e4_ru = 0; e4_gi = 0;
    endtask

    initial begin
        longint d0, d1, d2;
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_reset();
            end else begin
                if (flv) q.push_back(longint'(flen));
                if (!m_valid) begin
                    if (req) begin
                        stats(64'hFFFF_FFFF, e_fr, e_by, e_mn, e_mx, e_ru, e_gi);
                        stats(15, e4_fr, d0, d1, d2, e4_ru, e4_gi);
                        m_valid = 1;
                        if (clr) q.delete();
                    end
                end else begin
                    if (req) m_ovr = 1;
                    if (rdy) m_valid = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", a_valid, m_valid);
        chk("overrun", a_ovr, m_ovr);
        chk("valid4", b_valid, m_valid);
        chk("overrun4", b_ovr, m_ovr);
        if (m_valid) begin
            chk("frames", a_frames, e_fr);
            chk("bytes", a_bytes, e_by);
            chk("min_len", a_min, e_mn);
            chk("max_len", a_max, e_mx);
            chk("runts", a_runts, e_ru);
            chk("giants", a_giants, e_gi);
            chk("frames4", b_frames, e4_fr);
            chk("bytes4", b_bytes, e_by);
            chk("min_len4", b_min, e_mn);
            chk("max_len4", b_max, e_mx);
            chk("runts4", b_runts, e4_ru);
            chk("giants4", b_giants, e4_gi);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [15:0] l, input logic rq, input logic cl,
                        input logic rd);
        @(negedge clk);
        flv = v; flen = l; req = rq; clr = cl; rdy = rd;
    endtask

    task automatic idle();
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [15:0] l);
        step(1'b1, l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!a_valid && n < 8) begin
            idle();
            n++;
        end
        chk("wait_valid", a_valid, 1'b1);
    endtask

    task automatic snap(input logic cl);
        step(1'b0, 16'd0, 1'b1, cl, 1'b0);
        idle();
        wait_valid();
    endtask

    task automatic release_snap();
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic lit(input string tag, input longint fr, input longint by, input longint mn,
                       input longint mx, input longint ru, input longint gi);
        chk({tag, "_frames"}, a_frames, fr);
        chk({tag, "_bytes"}, a_bytes, by);
        chk({tag, "_min"}, a_min, mn);
        chk({tag, "_max"}, a_max, mx);
        chk({tag, "_runts"}, a_runts, ru);
        chk({tag, "_giants"}, a_giants, gi);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #12;
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_min", a_min, 16'hFFFF);
        chk("rst_frames", a_frames, 0);
        chk("rst_ovr", a_ovr, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        frame(16'd64); frame(16'd100); frame(16'd1518);
        snap(1'b1);
        lit("t1", 3, 1682, 64, 1518, 0, 0);
        release_snap();

        frame(16'd0); frame(16'd63); frame(16'd1519); frame(16'd9000);
        snap(1'b1);
        lit("t2", 4, 10582, 0, 9000, 2, 2);
        release_snap();

        snap(1'b1);
        lit("t3", 0, 0, 16'hFFFF, 0, 0, 0);
        release_snap();

        // frame in the same cycle as a clearing request belongs to that snapshot
        step(1'b1, 16'd200, 1'b1, 1'b1, 1'b0);
        idle();
        wait_valid();
        lit("t4", 1, 200, 200, 200, 0, 0);
        release_snap();
        snap(1'b1);
        lit("t4e", 0, 0, 16'hFFFF, 0, 0, 0);
        release_snap();

        // dropped requests while held: overrun set, shadow frozen, live not cleared
        frame(16'd300);
        snap(1'b0);
        step(1'b1, 16'd500, 1'b1, 1'b1, 1'b0);
        idle();
        chk("t5_ovr", a_ovr, 1'b1);
        lit("t5h", 1, 300, 300, 300, 0, 0);
        step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        idle();
        chk("t5_released", a_valid, 1'b0);
        snap(1'b1);
        lit("t5", 2, 800, 300, 500, 0, 0);
        release_snap();

        // counter saturation on the 4-bit instance, then asynchronous reset mid-hold
        for (int i = 0; i < 20; i++) frame(16'd10);
        snap(1'b0);
        lit("t6", 20, 200, 10, 10, 20, 0);
        chk("t6_frames4", b_frames, 15);
        chk("t6_runts4", b_runts, 15);
        chk("t6_bytes4", b_bytes, 200);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", a_valid, 1'b0);
        chk("t6_rst_valid4", b_valid, 1'b0);
        chk("t6_rst_ovr", a_ovr, 1'b0);
        chk("t6_rst_min", a_min, 16'hFFFF);
        chk("t6_rst_frames4", b_frames, 0);
        lit("t6r", 0, 0, 16'hFFFF, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        frame(16'd77);
        snap(1'b1);
        lit("t7", 1, 77, 77, 77, 0, 0);
        release_snap();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_len_stats.md
# axis_frame_len_stats

Frame-length statistics collector placed directly downstream of `axis_frame_len`. It consumes the `frame_len`/`frame_len_valid` pulse stream and accumulates per-period statistics: frame count, byte count, min/max length, and runt/giant counts. On request it publishes a coherent snapshot through a valid/ready handshake, optionally clearing the live counters, so management logic can read them.

## Interface
- `LEN_WIDTH`, 16: width of `frame_len`; must match upstream `axis_frame_len`.
- `COUNT_WIDTH`, 32: width of frame, runt and giant counters.
- `BYTE_WIDTH`, 48: width of byte accumulator.
- `MIN_LEN`, 64: frames with `frame_len < MIN_LEN` count as runts.
- `MAX_LEN`, 1518: frames with `frame_len > MAX_LEN` count as giants.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `frame_len`  in  LEN_WIDTH  length of the completed frame; valid only with `frame_len_valid`.
- `frame_len_valid`  in  1  one-cycle pulse per completed frame.
- `snapshot_req`  in  1  request snapshot; sampled each cycle.
- `snapshot_clear`  in  1  qualifies `snapshot_req`; clears live counters when the request is accepted.
- `stat_valid`  out  1  snapshot outputs valid.
- `stat_ready`  in  1  consumer accepts snapshot.
- `stat_frames`  out  COUNT_WIDTH  frames in period.
- `stat_bytes`  out  BYTE_WIDTH  sum of `frame_len` in period.
- `stat_min_len`  out  LEN_WIDTH  minimum length; all-ones if no frames.
- `stat_max_len`  out  LEN_WIDTH  maximum length; 0 if no frames.
- `stat_runts`  out  COUNT_WIDTH  runt count.
- `stat_giants`  out  COUNT_WIDTH  giant count.
- `snapshot_overrun`  out  1  sticky; set when a request is dropped.

## Operation
- Live registers: `frames`, `bytes`, `min_len`, `max_len`, `runts`, `giants`. Reset values: 0, 0, all-ones, 0, 0, 0.
- On `frame_len_valid`:
  - `frames`+1 and `bytes`+`frame_len`, both zero-extended.
  - `min_len` = min(`min_len`, `frame_len`); `max_len` = max(`max_len`, `frame_len`).
  - `runts`+1 if `frame_len < MIN_LEN`; `giants`+1 if `frame_len > MAX_LEN`.
  - A zero-length frame is counted and is a runt.
- All counters saturate at all-ones and never wrap. Once saturated they hold until cleared.
- FSM has two states:
  - IDLE: `stat_valid`=0. When `snapshot_req`=1, capture shadow registers and go to HOLD.
  - HOLD: `stat_valid`=1 and shadow registers are frozen. When `stat_ready`=1, go to IDLE.
- Captured value = live value including any `frame_len_valid` update in the same cycle. That frame belongs to the snapshot.
- If `snapshot_clear`=1 on acceptance, live registers load their reset values in the same edge. Frames arriving afterwards start the new period.
- `snapshot_req` while in HOLD, including the cycle `stat_ready` is high, is dropped. It sets `snapshot_overrun`, and live counters are not cleared.
- `snapshot_overrun` clears only on reset.
- Reset mid-operation: all outputs and live registers return to reset values immediately (asynchronous). A pending snapshot is lost.
- Reset values of all outputs: `stat_valid`=0, stats 0, `stat_min_len`=all-ones, `snapshot_overrun`=0.

## Timing
- Live counter update: 1 cycle after `frame_len_valid`.
- `stat_valid` rises on the edge that samples `snapshot_req` in IDLE (latency 1).
- Handshake completes on any edge with `stat_valid`&`stat_ready`; `stat_valid` falls that edge.
- Minimum snapshot spacing is 2 cycles (request, then accept).
- Back-to-back `frame_len_valid` on every cycle is supported; no input backpressure exists.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `axis_stats_pkg` holds:
  - the FSM state encoding (IDLE=0, HOLD=1);
  - default `MIN_LEN`/`MAX_LEN` constants, reused by future stats blocks.
- Sub-module `axis_sat_counter`: parameterised width and increment width, with `clear`, `inc_en` and `inc` inputs, saturating. Instantiate it four times: frames, bytes, runts, giants.
- Min/max tracking and the FSM live in the top module.

## Test plan
- Reset, then frames of length 64, 100, 1518 → snapshot with clear: frames=3, bytes=1682, min=64, max=1518, runts=0, giants=0.
- Frames of length 0, 63, 1519, 9000 → runts=2, giants=2, min=0, max=9000.
- Snapshot with no frames → frames=0, bytes=0, min=0xFFFF, max=0.
- `frame_len_valid` (len 200) and `snapshot_req`+`snapshot_clear` in the same cycle → snapshot includes 200; the next empty snapshot has frames=0.
- Hold `stat_ready`=0 and pulse `snapshot_req` again → `snapshot_overrun`=1, shadow unchanged, live counters not cleared.
- With `COUNT_WIDTH`=4, send 20 frames → frames=15 (saturated). Assert `rst`=0 mid-HOLD → `stat_valid`=0 immediately and all stats return to reset values.
